// File: rtl/nios2_pio_irq_if.sv
// Avalon-MM slave bus bundle for the NIOS2 PIO block.
interface nios2_pio_irq_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios2_pio_irq.sv
// Parametrised Avalon-MM GPIO slave: direction, atomic set/clear, synchronised
// inputs, sticky edge capture (W1C) and a masked, registered IRQ.
module nios2_pio_bit #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_i,
  input  logic dir_i,
  input  logic primed_i,
  input  logic clr_i,
  output logic sync_o,
  output logic cap_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic prev_q, cap_q, cap_d;
  logic rise, fall, hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cap_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_q <= sync_q[SYNC_STAGES-1];
      cap_q  <= cap_d;
    end
  end

  // A fresh edge beats a simultaneous write-1-to-clear.
  always_comb begin
    rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    fall = ~sync_q[SYNC_STAGES-1] & prev_q;
    case (EDGE_TYPE)
      0:       hit = rise;
      1:       hit = fall;
      default: hit = rise | fall;
    endcase
    cap_d = (cap_q & ~clr_i) | (hit & ~dir_i & primed_i);
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign cap_o  = cap_q;
endmodule

module nios2_pio_irq #(
  parameter int          WIDTH       = 4,
  parameter int          SYNC_STAGES = 2,
  parameter int          EDGE_TYPE   = 0,
  parameter int          IRQ_MODE    = 1,
  parameter logic [31:0] RESET_OUT   = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  nios2_pio_irq_if.slave   bus,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);
  localparam int PRIME_MAX = SYNC_STAGES + 1;

  logic             wr, primed;
  logic [WIDTH-1:0] wdata, clr, sync_in, edgecap;
  logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d, mask_q, mask_d;
  logic [31:0]      rd_q, rd_d;
  logic [2:0]       prime_q;
  logic             irq_q, irq_d;

  assign wr     = bus.chipselect & ~bus.write_n;
  assign wdata  = bus.writedata[WIDTH-1:0];
  assign clr    = (wr && bus.address == 3'd3) ? wdata : '0;
  // Hold off edge capture until the synchroniser and prev stage hold real pin data.
  assign primed = (prime_q == 3'(PRIME_MAX));

  nios2_pio_bit #(.SYNC_STAGES(SYNC_STAGES), .EDGE_TYPE(EDGE_TYPE)) u_bit [WIDTH-1:0] (
    .clk      (clk),
    .reset_n  (reset_n),
    .pin_i    (in_port),
    .dir_i    (dir_q),
    .primed_i (primed),
    .clr_i    (clr),
    .sync_o   (sync_in),
    .cap_o    (edgecap)
  );

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    if (wr) begin
      case (bus.address)
        3'd0:    out_d  = wdata;
        3'd1:    dir_d  = wdata;
        3'd2:    mask_d = wdata;
        3'd4:    out_d  = out_q | wdata;
        3'd5:    out_d  = out_q & ~wdata;
        default: ;
      endcase
    end

    rd_d = '0;
    case (bus.address)
      3'd0:    rd_d[WIDTH-1:0] = (dir_q & out_q) | (~dir_q & sync_in);
      3'd1:    rd_d[WIDTH-1:0] = dir_q;
      3'd2:    rd_d[WIDTH-1:0] = mask_q;
      3'd3:    rd_d[WIDTH-1:0] = edgecap;
      default: ;
    endcase

    irq_d = (IRQ_MODE == 1) ? |(edgecap & mask_q) : |(sync_in & ~dir_q & mask_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q   <= RESET_OUT[WIDTH-1:0];
      dir_q   <= '0;
      mask_q  <= '0;
      rd_q    <= '0;
      irq_q   <= 1'b0;
      prime_q <= '0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      mask_q  <= mask_d;
      rd_q    <= rd_d;
      irq_q   <= irq_d;
      prime_q <= primed ? prime_q : prime_q + 3'd1;
    end
  end

  assign bus.readdata = rd_q;
  assign out_port     = out_q;
  assign oe           = dir_q;
  assign irq          = irq_q;
endmodule

// File: tb/tb_nios2_pio_irq.sv
// Scoreboard bench for nios2_pio_irq: edge-capture and level-IRQ instances share one bus.
module tb_nios2_pio_irq;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] in_port;
  logic [3:0] out_e, oe_e, out_l, oe_l;
  logic       irq_e, irq_l;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] exp;
    int          due;
  } sb_t;
  sb_t sb[$];

  nios2_pio_irq_if bus_e ();
  nios2_pio_irq_if bus_l ();

  assign bus_l.address    = bus_e.address;
  assign bus_l.chipselect = bus_e.chipselect;
  assign bus_l.write_n    = bus_e.write_n;
  assign bus_l.writedata  = bus_e.writedata;

  nios2_pio_irq #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(1), .RESET_OUT(32'h0)) dut_e (
    .clk(clk), .reset_n(reset_n), .bus(bus_e), .in_port(in_port),
    .out_port(out_e), .oe(oe_e), .irq(irq_e));

  nios2_pio_irq #(.WIDTH(4), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(0), .RESET_OUT(32'h0)) dut_l (
    .clk(clk), .reset_n(reset_n), .bus(bus_l), .in_port(in_port),
    .out_port(out_l), .oe(oe_l), .irq(irq_l));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] obs(int k);
    case (k)
      0:       return bus_e.readdata;
      1:       return 32'(out_e);
      2:       return 32'(irq_e);
      3:       return 32'(irq_l);
      4:       return 32'(oe_e);
      default: return 'x;
    endcase
  endfunction

  task automatic sb_push(int kind, logic [31:0] exp, int dly, string tag);
    sb_t e;
    e.tag = tag; e.kind = kind; e.exp = exp; e.due = cyc + dly;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        chk(sb[i].tag, obs(sb[i].kind), sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(logic [2:0] a, logic [31:0] d);
    @(negedge clk);
    bus_e.address = a; bus_e.chipselect = 1'b1; bus_e.write_n = 1'b0; bus_e.writedata = d;
    @(negedge clk);
    bus_e.chipselect = 1'b0; bus_e.write_n = 1'b1;
  endtask

  task automatic rd(logic [2:0] a, logic [31:0] e, string tag);
    @(negedge clk);
    bus_e.address = a;
    sb_push(0, e, 1, tag);
  endtask

  initial begin
    bus_e.address = '0; bus_e.chipselect = 1'b0; bus_e.write_n = 1'b1; bus_e.writedata = '0;
    in_port = '0; reset_n = 1'b0;
    tick(3);
    chk("rst_out", 32'(out_e), 0);
    chk("rst_oe", 32'(oe_e), 0);
    chk("rst_irq", 32'(irq_e), 0);
    chk("rst_rd", bus_e.readdata, 0);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) rd(3'(a), 0, "rst_rd_addr");
    sb_push(1, 0, 1, "rst_out_port");
    sb_push(2, 0, 1, "rst_irq_e");

    // Direction and data mux; upper writedata bits must be dropped.
    wr(1, 32'hFFFF_FFF3);
    wr(0, 32'hFFFF_FFF5);
    sb_push(4, 32'h3, 1, "oe");
    sb_push(1, 32'h5, 1, "out_data");
    @(negedge clk) in_port = 4'b1000;
    tick(3);
    rd(0, 32'h9, "data_mix");
    rd(3, 32'h8, "cap_in3");
    rd(1, 32'h3, "dir_rd");
    wr(3, 32'hF);
    rd(3, 32'h0, "cap_w1c");

    // Atomic set/clear.
    wr(4, 32'h8);
    sb_push(1, 32'hD, 1, "outset");
    wr(5, 32'h1);
    sb_push(1, 32'hC, 1, "outclr");
    rd(4, 0, "rd_outset");
    rd(5, 0, "rd_outclr");
    wr(6, 32'hF);
    wr(7, 32'hF);
    rd(6, 0, "rd6");
    rd(7, 0, "rd7");
    sb_push(1, 32'hC, 1, "out_hold");

    // Rising edge on bit 2, masked IRQ, then W1C.
    in_port = 4'b0000;
    tick(4);
    wr(3, 32'hF);
    wr(2, 32'h4);
    @(negedge clk) in_port = 4'b0100;
    sb_push(2, 0, 3, "irq_e_pre");
    sb_push(2, 1, 4, "irq_e_set");
    rd(3, 0, "cap_e1");
    rd(3, 0, "cap_e2");
    rd(3, 32'h4, "cap_e3");
    tick(2);
    wr(3, 32'h4);
    chk("irq_e_hold", 32'(irq_e), 1);
    sb_push(2, 0, 1, "irq_e_clr");

    // W1C on the same clock as a new rising edge on bit 2.
    tick(2);
    in_port = 4'b0000; tick(4);
    in_port = 4'b0100; tick(4);
    in_port = 4'b0000; tick(4);
    in_port = 4'b0100; tick(1);
    wr(3, 32'h4);
    sb_push(2, 1, 1, "irq_collide");
    rd(3, 32'h4, "cap_collide");
    wr(3, 32'hF);

    // Level IRQ on bit 0 in the second instance.
    wr(1, 32'h0);
    wr(2, 32'h1);
    tick(2);
    @(negedge clk) in_port = 4'b0001;
    sb_push(3, 0, 2, "irq_l_pre");
    sb_push(3, 1, 3, "irq_l_set");
    tick(4);
    sb_push(2, 1, 1, "irq_e_bit0");
    @(negedge clk) in_port = 4'b0000;
    sb_push(3, 1, 2, "irq_l_hold");
    sb_push(3, 0, 3, "irq_l_clr");
    tick(4);

    // Asynchronous reset while a capture is pending.
    chk("irq_e_pre_rst", 32'(irq_e), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_irq_e", 32'(irq_e), 0);
    chk("arst_out", 32'(out_e), 0);
    chk("arst_oe", 32'(oe_e), 0);
    chk("arst_rd", bus_e.readdata, 0);

    // Pins held high through reset release must not register an edge.
    in_port = 4'hF;
    tick(3);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) rd(3, 0, "prime_cap");
    rd(0, 32'hF, "prime_data");

    for (int i = 0; i < 20 && sb.size() > 0; i++) tick(1);
    chk("sb_drain", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
